// File: rtl/bank_tag_pkg.sv
// Shared constants and helpers for the bank tag lookup block.
package bank_tag_pkg;

    localparam int MAX_BANKS = 16;
    localparam int CNT_W     = 5;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_BANKS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_BANKS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bank_tag_lookup_prio_enc.sv
// Lowest-index priority encoder with any/multi flags over an N-bit vector.
module bank_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    // Scan from the top down so the lowest set bit lands last
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set
    always_comb begin
        any   = |vec;
        multi = |(vec & (vec - N'(1)));
    end

endmodule

// File: rtl/bank_tag_lookup.sv
// Registered NUM_BANKS-way tag lookup with fill/invalidate side port.
// Optional macro BANK_TAG_LOOKUP_FILL_BYPASS_EN forwards a same-cycle fill into the compare.
module bank_tag_lookup
    import bank_tag_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int TAG_W     = 9,
    localparam int IDX_W    = clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [NUM_BANKS-1:0] rsp_select,
    output logic [IDX_W-1:0]     rsp_idx,
    output logic                 rsp_multi,
    output logic [IDX_W-1:0]     rsp_victim,
    input  logic                 fill_valid,
    input  logic [IDX_W-1:0]     fill_bank,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic                 inv_all,
    output logic [IDX_W:0]       occupancy
);

    localparam logic [IDX_W:0]   BANK_LIM = (IDX_W + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0] RR_LAST  = IDX_W'(NUM_BANKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [NUM_BANKS-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r [NUM_BANKS];
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W:0]       occupancy_r;

    logic                 rsp_valid_r;
    logic                 rsp_hit_r;
    logic [NUM_BANKS-1:0] rsp_select_r;
    logic [IDX_W-1:0]     rsp_idx_r;
    logic                 rsp_multi_r;
    logic [IDX_W-1:0]     rsp_victim_r;

    logic                 fill_eff_s;
    logic                 accept_s;
    logic [NUM_BANKS-1:0] view_valid_s;
    logic [TAG_W-1:0]     view_tag_s [NUM_BANKS];
    logic [NUM_BANKS-1:0] match_s;
    logic                 hit_s;
    logic                 multi_s;
    logic [IDX_W-1:0]     hit_idx_s;
    logic                 inv_any_s;
    logic [IDX_W-1:0]     inv_idx_s;
    logic                 inv_multi_unused_s;
    logic [IDX_W-1:0]     victim_s;
    logic [NUM_BANKS-1:0] valid_nx_s;
    logic [TAG_W-1:0]     tag_nx_s [NUM_BANKS];
    logic [IDX_W-1:0]     rr_nx_s;

    // Out-of-range banks are dropped, and invalidate overrides any fill
    assign fill_eff_s = fill_valid && !inv_all && ({1'b0, fill_bank} < BANK_LIM);
    assign req_ready  = !rsp_valid_r || rsp_ready;
    assign accept_s   = req_valid && req_ready;

`ifdef BANK_TAG_LOOKUP_FILL_BYPASS_EN
    // Compare view: registered contents with the same-cycle fill forwarded in
    always_comb begin
        view_valid_s = valid_r;
        view_tag_s   = tag_r;
        if (fill_eff_s) begin
            view_valid_s[fill_bank] = 1'b1;
            view_tag_s[fill_bank]   = fill_tag;
        end else begin
            view_valid_s = valid_r;
        end
    end
`else
    // Compare view: registered contents only
    always_comb begin
        view_valid_s = valid_r;
        view_tag_s   = tag_r;
    end
`endif

    // Per-bank match vector; invalid banks never match
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            match_s[i] = view_valid_s[i] && (view_tag_s[i] == req_tag);
        end
    end

    bank_prio_enc #(.N(NUM_BANKS), .IW(IDX_W)) u_hit_enc (
        .vec   (match_s),
        .idx   (hit_idx_s),
        .any   (hit_s),
        .multi (multi_s)
    );

    bank_prio_enc #(.N(NUM_BANKS), .IW(IDX_W)) u_free_enc (
        .vec   (~view_valid_s),
        .idx   (inv_idx_s),
        .any   (inv_any_s),
        .multi (inv_multi_unused_s)
    );

    // Victim: none on hit, else first free bank, else round-robin pointer
    always_comb begin
        if (hit_s) begin
            victim_s = '0;
        end else if (inv_any_s) begin
            victim_s = inv_idx_s;
        end else begin
            victim_s = rr_ptr_r;
        end
    end

    // Next tag-store state from fill / invalidate
    always_comb begin
        valid_nx_s = valid_r;
        tag_nx_s   = tag_r;
        rr_nx_s    = rr_ptr_r;
        if (inv_all) begin
            valid_nx_s = '0;
            rr_nx_s    = '0;
        end else if (fill_eff_s) begin
            valid_nx_s[fill_bank] = 1'b1;
            tag_nx_s[fill_bank]   = fill_tag;
            if (fill_bank == rr_ptr_r) begin
                rr_nx_s = (rr_ptr_r == RR_LAST) ? '0 : rr_ptr_r + IDX_ONE;
            end else begin
                rr_nx_s = rr_ptr_r;
            end
        end else begin
            rr_nx_s = rr_ptr_r;
        end
    end

    // Tag store, round-robin pointer and post-edge occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r     <= '0;
            rr_ptr_r    <= '0;
            occupancy_r <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            valid_r     <= valid_nx_s;
            tag_r       <= tag_nx_s;
            rr_ptr_r    <= rr_nx_s;
            occupancy_r <= (IDX_W + 1)'(popcount(MAX_BANKS'(valid_nx_s)));
        end
    end

    // Response stage: load on accept, hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_hit_r    <= 1'b0;
            rsp_select_r <= '0;
            rsp_idx_r    <= '0;
            rsp_multi_r  <= 1'b0;
            rsp_victim_r <= '0;
        end else if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_hit_r    <= hit_s;
            rsp_select_r <= match_s;
            rsp_idx_r    <= hit_idx_s;
            rsp_multi_r  <= multi_s;
            rsp_victim_r <= victim_s;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_hit    = rsp_hit_r;
    assign rsp_select = rsp_select_r;
    assign rsp_idx    = rsp_idx_r;
    assign rsp_multi  = rsp_multi_r;
    assign rsp_victim = rsp_victim_r;
    assign occupancy  = occupancy_r;

endmodule

// File: tb/tb_bank_tag_lookup.sv
// Randomized + directed bench for bank_tag_lookup against a behavioural bank model.
module tb_bank_tag_lookup;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [8:0]    req_tag, fill_tag;
    logic          rsp_hit, rsp_multi, fill_valid, inv_all;
    logic [NB-1:0] rsp_select;
    logic [1:0]    rsp_idx, rsp_victim, fill_bank;
    logic [2:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    bit         m_valid [NB];
    logic [8:0] m_tag   [NB];
    int         m_rr;
    bit         e_valid, e_hit, e_multi;
    logic [NB-1:0] e_sel;
    int         e_idx, e_victim;

`ifdef BANK_TAG_LOOKUP_FILL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    bank_tag_lookup dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_select(rsp_select), .rsp_idx(rsp_idx), .rsp_multi(rsp_multi),
        .rsp_victim(rsp_victim), .fill_valid(fill_valid), .fill_bank(fill_bank),
        .fill_tag(fill_tag), .inv_all(inv_all), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_rr = 0; e_valid = 0; e_hit = 0; e_multi = 0; e_sel = '0; e_idx = 0; e_victim = 0;
    endtask

    function automatic int model_occ();
        int c = 0;
        for (int i = 0; i < NB; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // Called at a negedge with inputs already driven; checks across one clock edge.
    task automatic step();
        bit            acc;
        bit            vv [NB];
        logic [8:0]    vt [NB];
        logic [NB-1:0] sel;
        int            fb;
        #1;
        check_eq("req_ready", req_ready, (!e_valid || rsp_ready));
        acc = req_valid && (!e_valid || rsp_ready);
        fb  = int'(fill_bank);
        vv  = m_valid;
        vt  = m_tag;
        if (BYP && fill_valid && !inv_all) begin
            vv[fb] = 1'b1;
            vt[fb] = fill_tag;
        end
        if (acc) begin
            sel = '0;
            for (int i = 0; i < NB; i++) if (vv[i] && vt[i] == req_tag) sel[i] = 1'b1;
            e_valid = 1; e_sel = sel; e_hit = (sel != '0); e_multi = ($countones(sel) > 1);
            e_idx = 0;
            for (int i = 0; i < NB; i++) if (sel[i]) begin e_idx = i; break; end
            e_victim = m_rr;
            for (int i = 0; i < NB; i++) if (!vv[i]) begin e_victim = i; break; end
            if (e_hit) e_victim = 0;
        end else if (rsp_ready) begin
            e_valid = 0;
        end
        if (inv_all) begin
            for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
            m_rr = 0;
        end else if (fill_valid) begin
            m_valid[fb] = 1'b1;
            m_tag[fb]   = fill_tag;
            if (fb == m_rr) m_rr = (m_rr + 1) % NB;
        end
        @(posedge clk);
        #1;
        check_eq("rsp_valid", rsp_valid, e_valid);
        check_eq("rsp_hit", rsp_hit, e_hit);
        check_eq("rsp_select", rsp_select, e_sel);
        check_eq("rsp_idx", rsp_idx, e_idx);
        check_eq("rsp_multi", rsp_multi, e_multi);
        check_eq("rsp_victim", rsp_victim, e_victim);
        check_eq("occupancy", occupancy, model_occ());
        @(negedge clk);
    endtask

    task automatic cyc(input bit rv, input logic [8:0] t, input bit rr,
                       input bit fv, input logic [1:0] fb, input logic [8:0] ft, input bit inv);
        req_valid = rv; req_tag = t; rsp_ready = rr;
        fill_valid = fv; fill_bank = fb; fill_tag = ft; inv_all = inv;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_hit"}, rsp_hit, 0);
        check_eq({tag, "_rsp_select"}, rsp_select, 0);
        check_eq({tag, "_rsp_idx"}, rsp_idx, 0);
        check_eq({tag, "_rsp_multi"}, rsp_multi, 0);
        check_eq({tag, "_rsp_victim"}, rsp_victim, 0);
        check_eq({tag, "_occupancy"}, occupancy, 0);
        check_eq({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        logic [8:0] pool [4];
        pool[0] = 9'h010; pool[1] = 9'h020; pool[2] = 9'h030; pool[3] = 9'h040;
        rst = 1'b1; req_valid = 0; req_tag = '0; rsp_ready = 1; fill_valid = 0;
        fill_bank = '0; fill_tag = '0; inv_all = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single valid bank: miss picks the first free bank
        cyc(0, 9'h000, 1, 1, 2'd0, 9'h010, 0);
        cyc(1, 9'h1FF, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t2_hit", rsp_hit, 0);
        check_eq("t2_victim", rsp_victim, 1);

        // Four banks filled; lookup hits bank 2
        for (int i = 0; i < NB; i++) cyc(0, 9'h000, 1, 1, 2'(i), pool[i], 0);
        cyc(1, 9'h030, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t1_hit", rsp_hit, 1);
        check_eq("t1_select", rsp_select, 4'b0100);
        check_eq("t1_idx", rsp_idx, 2);
        check_eq("t1_occ", occupancy, 4);

        // Round-robin victim when full
        cyc(1, 9'h1FF, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t3_victim0", rsp_victim, 0);
        cyc(0, 9'h000, 1, 1, 2'd0, 9'h010, 0);
        cyc(1, 9'h1FF, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t3_victim1", rsp_victim, 1);
        cyc(0, 9'h000, 1, 1, 2'd3, 9'h040, 0);
        cyc(1, 9'h1FF, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t3_victim_hold", rsp_victim, 1);

        // Backpressure: response held, then new request taken as ready rises
        cyc(0, 9'h000, 1, 0, 2'd0, 9'h000, 0);
        cyc(1, 9'h020, 0, 0, 2'd0, 9'h000, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 9'h030, 0, 0, 2'd0, 9'h000, 0);
            check_eq("t4_hold_idx", rsp_idx, 1);
        end
        cyc(1, 9'h030, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t4_new_idx", rsp_idx, 2);

        // Same-cycle fill vs lookup, then duplicate tags
        cyc(0, 9'h000, 1, 0, 2'd0, 9'h000, 1);
        cyc(0, 9'h000, 1, 1, 2'd0, 9'h010, 0);
        cyc(1, 9'h020, 1, 1, 2'd1, 9'h020, 0);
        check_eq("t5_bypass_hit", rsp_hit, BYP);
        cyc(0, 9'h000, 1, 1, 2'd2, 9'h020, 0);
        cyc(1, 9'h020, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t5_multi", rsp_multi, 1);
        check_eq("t5_idx", rsp_idx, 1);
        check_eq("t5_select", rsp_select, 4'b0110);

        // Invalidate beats a same-cycle fill
        cyc(0, 9'h000, 1, 1, 2'd3, 9'h010, 1);
        check_eq("t6_occ", occupancy, 0);
        cyc(1, 9'h010, 1, 0, 2'd0, 9'h000, 0);
        check_eq("t6_hit", rsp_hit, 0);

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(3) != 0),
                ($urandom_range(4) == 0) ? 9'($urandom) : pool[$urandom_range(3)],
                ($urandom_range(2) != 0),
                ($urandom_range(3) == 0), 2'($urandom_range(3)),
                pool[$urandom_range(3)], ($urandom_range(31) == 0));
        end

        // Asynchronous reset in the middle of a held response
        cyc(0, 9'h000, 1, 1, 2'd0, 9'h030, 0);
        cyc(1, 9'h030, 0, 0, 2'd0, 9'h000, 0);
        check_eq("t6_pre_valid", rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 9'h030, 1, 0, 2'd0, 9'h000, 0);
        check_eq("post_rst_hit", rsp_hit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
